rr_arbiter_8: RTL and testbench
===============================

RR_ARBITER_8 -- requirements
Module: rr_arbiter_8

Interface
REQ-001 Parameter MAX_HOLD, default 16, SHALL set the maximum consecutive GRANT cycles before forced rotation; legal range 2..255.
REQ-002 clk  input  1  SHALL be the single clock; all state updates occur on its rising edge.
REQ-003 rst  input  1  SHALL be the reset, asynchronous and active-high.
REQ-004 req  input  8  SHALL carry requester i's level-sensitive request on req[i].
REQ-005 sel  output 3  SHALL carry the registered index of the current owner, driving the 3x8 decoder select.
REQ-006 en  output 1  SHALL be the registered grant-valid signal, driving the decoder enable.
REQ-007 gnt  output 8  SHALL be the one-hot grant, equal to the decode of sel gated by en; all zeros when en=0.
REQ-008 busy  output 1  SHALL be high whenever the state is GRANT or GAP.

Function
REQ-009 The FSM SHALL have exactly three states: IDLE, GRANT and GAP.
REQ-010 Winner selection SHALL search req from index ptr upward, wrapping 7->0, and pick the first asserted bit.
REQ-011 IDLE with req!=0 SHALL go to GRANT on the next edge with sel=winner and en=1 (one-cycle request-to-grant latency).
REQ-012 IDLE with req==0 SHALL hold IDLE with en=0.
REQ-013 On every new grant, ptr SHALL load (winner+1) mod 8 and the hold counter SHALL load 1.
REQ-014 GRANT SHALL persist while req[sel]=1 and the counter is below MAX_HOLD; the counter SHALL increment each GRANT cycle.
REQ-015 In GRANT, req[sel]=0 SHALL cause the next state GAP with en=0.
REQ-016 In GRANT, counter=MAX_HOLD with any other req bit set SHALL force the next state GAP (pre-emption).
REQ-017 In GRANT, counter=MAX_HOLD with no other request pending SHALL hold GRANT, with the counter saturated at MAX_HOLD.
REQ-018 Release and timeout in the same cycle SHALL be treated as a release; the resulting behaviour is identical.
REQ-019 GAP SHALL last exactly one cycle with en=0 and gnt=0, as a turnaround cycle that guarantees no back-to-back grant overlap.
REQ-020 GAP SHALL go to GRANT using the REQ-010 search if req!=0, otherwise to IDLE.
REQ-021 A pre-empted owner still requesting in GAP SHALL lose to any other pending requester, because ptr already points past it.
REQ-022 sel SHALL hold its last value while en=0; consumers SHALL qualify sel with en.
REQ-023 gnt SHALL never have more than one bit set in any cycle.

Reset
REQ-024 Asserting rst SHALL immediately force state=IDLE, sel=0, en=0, gnt=0, busy=0, ptr=0 and counter=0, regardless of clk.
REQ-025 Reset asserted mid-GRANT SHALL drop the grant without a GAP cycle.
REQ-026 After reset release, the first arbitration SHALL give req[0] highest priority.

Structure
REQ-027 Package rr_arbiter_pkg SHALL hold the state encoding (IDLE, GRANT, GAP), NUM_REQ=8, IDX_W=3 and CNT_W=8.
REQ-028 A single sub-module, gnt_decode_3x8, SHALL implement the sel/en to one-hot gnt decode; everything else stays in rr_arbiter_8.
REQ-029 The winner search SHALL be combinational; sel, en, ptr, counter and state SHALL be registered.

Verification
REQ-030 The bench SHALL cover: reset, then req=8'b0000_0100 -> one cycle later sel=2, en=1, gnt=8'h04, busy=1.
REQ-031 The bench SHALL cover: owner 2 drops req with req[5] pending -> one GAP cycle with gnt=0, then sel=5, gnt=8'h20.
REQ-032 The bench SHALL cover: req=8'hFF held with MAX_HOLD=4 -> grants cycle 0,1,2,...,7,0, each lasting 4 cycles, separated by single GAP cycles.
REQ-033 The bench SHALL cover: only req[3] held for 40 cycles with MAX_HOLD=16 -> continuous grant to 3, no GAP, counter stuck at 16.
REQ-034 The bench SHALL cover: rst pulsed mid-GRANT between clock edges -> en=0 and gnt=0 immediately, then after release req=8'h81 -> sel=0 wins.
REQ-035 The bench SHALL cover: the owner's release and MAX_HOLD expiry coinciding -> exactly one GAP cycle, then the next winner per REQ-010.
REQ-036 All benches SHALL check, every cycle, that gnt is one-hot or zero and that gnt equals the decode of sel gated by en.

Source files
------------

// File: rtl/rr_arbiter_pkg.sv
// Shared types and constants for the 8-way round-robin arbiter.
package rr_arbiter_pkg;

  localparam int NUM_REQ = 8;
  localparam int IDX_W   = 3;
  localparam int CNT_W   = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_GAP   = 2'd2
  } state_e;

  typedef struct packed {
    logic             found;
    logic [IDX_W-1:0] idx;
  } pick_t;

  // Lowest set bit of a request vector that has already been rotated so
  // that bit 0 is the highest-priority position.
  function automatic pick_t first_set(input logic [NUM_REQ-1:0] v);
    pick_t p;
    p.found = 1'b0;
    p.idx   = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (v[i]) begin
        p.found = 1'b1;
        p.idx   = IDX_W'(i);
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/rr_arbiter_8_gnt_decode.sv
// Select/enable to one-hot grant decode. Grant is all zeros while en is low,
// so a stale sel never produces a grant.
module gnt_decode_3x8
  import rr_arbiter_pkg::*;
(
  input  logic [IDX_W-1:0]   sel,
  input  logic               en,
  output logic [NUM_REQ-1:0] gnt
);

  // Decode sel into a single asserted grant line, gated by en.
  always_comb begin
    gnt = '0;
    if (en) begin
      gnt[sel] = 1'b1;
    end
  end

endmodule

// File: rtl/rr_arbiter_8.sv
// 8-requester round-robin arbiter with a bounded hold time and a one-cycle
// turnaround (GAP) between successive owners.
module rr_arbiter_8
  import rr_arbiter_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 16
)(
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  output logic [IDX_W-1:0]   sel,
  output logic               en,
  output logic [NUM_REQ-1:0] gnt,
  output logic               busy
);

  if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_max_hold
    $error("rr_arbiter_8: MAX_HOLD must lie in 2..255");
  end

  localparam logic [CNT_W-1:0] HOLD_LIMIT = CNT_W'(MAX_HOLD);

  state_e             state;
  logic [IDX_W-1:0]   ptr;
  logic [CNT_W-1:0]   hold_cnt;

  logic [2*NUM_REQ-1:0] req_dbl;
  logic [NUM_REQ-1:0]   req_rot;
  pick_t                pick;
  logic [IDX_W-1:0]     win_idx;

  logic [NUM_REQ-1:0]   owner_mask;
  logic                 owner_req;
  logic                 others_pend;
  logic                 at_max;
  logic                 release_c;
  logic                 preempt_c;

  // Round-robin winner: rotate req so ptr lands on bit 0, take the first set
  // bit, then map back to an absolute index (3-bit add wraps 7->0).
  always_comb begin
    req_dbl = {req, req};
    req_rot = req_dbl[ptr +: NUM_REQ];
    pick    = first_set(req_rot);
    win_idx = ptr + pick.idx;
  end

  // Exit conditions for the current owner. A release that coincides with a
  // timeout is simply a release; both lead to the same GAP.
  always_comb begin
    owner_mask  = NUM_REQ'(1) << sel;
    owner_req   = req[sel];
    others_pend = |(req & ~owner_mask);
    at_max      = (hold_cnt >= HOLD_LIMIT);
    release_c   = ~owner_req;
    preempt_c   = owner_req & at_max & others_pend;
  end

  // Arbitration FSM with registered sel/en, rotation pointer and hold counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      sel      <= '0;
      en       <= 1'b0;
      ptr      <= '0;
      hold_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_GAP: begin
          if (pick.found) begin
            state    <= ST_GRANT;
            sel      <= win_idx;
            en       <= 1'b1;
            ptr      <= win_idx + IDX_W'(1);
            hold_cnt <= CNT_W'(1);
          end else begin
            state <= ST_IDLE;
            en    <= 1'b0;
          end
        end
        ST_GRANT: begin
          if (release_c || preempt_c) begin
            state <= ST_GAP;
            en    <= 1'b0;
          end else if (!at_max) begin
            hold_cnt <= hold_cnt + CNT_W'(1);
          end
        end
        default: begin
          state <= ST_IDLE;
          en    <= 1'b0;
        end
      endcase
    end
  end

  // Busy covers both the owning cycles and the turnaround cycle.
  always_comb begin
    busy = (state == ST_GRANT) || (state == ST_GAP);
  end

  gnt_decode_3x8 u_gnt_decode (
    .sel (sel),
    .en  (en),
    .gnt (gnt)
  );

endmodule

// File: tb/tb_rr_arbiter_8.sv
// Self-checking bench: two arbiters (MAX_HOLD 4 and 16) share one request
// bus and are compared every cycle against a behavioural round-robin model.
module tb_rr_arbiter_8;

  localparam int MH0 = 4;
  localparam int MH1 = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] req;

  logic [2:0] sel_w  [2];
  logic       en_w   [2];
  logic [7:0] gnt_w  [2];
  logic       busy_w [2];

  rr_arbiter_8 #(.MAX_HOLD(MH0)) dut4 (
    .clk (clk), .rst (rst), .req (req),
    .sel (sel_w[0]), .en (en_w[0]), .gnt (gnt_w[0]), .busy (busy_w[0])
  );

  rr_arbiter_8 #(.MAX_HOLD(MH1)) dut16 (
    .clk (clk), .rst (rst), .req (req),
    .sel (sel_w[1]), .en (en_w[1]), .gnt (gnt_w[1]), .busy (busy_w[1])
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: who owns the bus, whether we are in the turnaround
  // cycle, where the next search starts and how long the owner has held.
  typedef struct {
    bit own_v;
    bit gap;
    int owner;
    int ptr;
    int held;
  } ms_t;

  int  mh [2] = '{MH0, MH1};
  ms_t ms [2];

  function automatic ms_t model_step(input ms_t s, input logic [7:0] r, input int h);
    ms_t n;
    int  pick;
    bit  others;
    n    = s;
    pick = -1;
    if (s.own_v) begin
      others = (r & ~(8'(1) << s.owner)) != 8'h00;
      if (!r[s.owner] || (s.held >= h && others)) begin
        n.own_v = 1'b0;
        n.gap   = 1'b1;
      end else if (s.held < h) begin
        n.held = s.held + 1;
      end
    end else begin
      n.gap = 1'b0;
      for (int k = 0; k < 8; k++)
        if (pick < 0 && r[(s.ptr + k) % 8]) pick = (s.ptr + k) % 8;
      if (pick >= 0) begin
        n.own_v = 1'b1;
        n.owner = pick;
        n.ptr   = (pick + 1) % 8;
        n.held  = 1;
      end
    end
    return n;
  endfunction

  always @(posedge clk or posedge rst) begin
    for (int m = 0; m < 2; m++) begin
      if (rst) ms[m] <= '{own_v: 1'b0, gap: 1'b0, owner: 0, ptr: 0, held: 0};
      else     ms[m] <= model_step(ms[m], req, mh[m]);
    end
  end

  // Advance to the next falling edge and check both DUTs against the model
  // and against the grant invariants.
  task automatic tick();
    logic [7:0] exp_gnt;
    logic [7:0] dec;
    @(negedge clk);
    for (int m = 0; m < 2; m++) begin
      exp_gnt = ms[m].own_v ? (8'(1) << ms[m].owner) : 8'h00;
      check_eq($sformatf("model_en[%0d]", m),   32'(en_w[m]),   32'(ms[m].own_v));
      check_eq($sformatf("model_sel[%0d]", m),  32'(sel_w[m]),  32'(ms[m].owner));
      check_eq($sformatf("model_gnt[%0d]", m),  32'(gnt_w[m]),  32'(exp_gnt));
      check_eq($sformatf("model_busy[%0d]", m), 32'(busy_w[m]), 32'(ms[m].own_v | ms[m].gap));
      check_eq($sformatf("onehot0[%0d]", m),    32'($countones(gnt_w[m]) <= 1), 32'd1);
      dec = en_w[m] ? (8'(1) << sel_w[m]) : 8'h00;
      check_eq($sformatf("decode[%0d]", m),     32'(gnt_w[m]),  32'(dec));
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = 8'h00;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    req = 8'h00;
    tick();
    tick();
    for (int m = 0; m < 2; m++) begin
      check_eq($sformatf("rst_sel[%0d]", m),  32'(sel_w[m]),  32'd0);
      check_eq($sformatf("rst_en[%0d]", m),   32'(en_w[m]),   32'd0);
      check_eq($sformatf("rst_gnt[%0d]", m),  32'(gnt_w[m]),  32'd0);
      check_eq($sformatf("rst_busy[%0d]", m), 32'(busy_w[m]), 32'd0);
    end
    rst = 1'b0;

    // Single request: granted one cycle later.
    req = 8'h04;
    tick();
    check_eq("first_sel",  32'(sel_w[1]),  32'd2);
    check_eq("first_en",   32'(en_w[1]),   32'd1);
    check_eq("first_gnt",  32'(gnt_w[1]),  32'h04);
    check_eq("first_busy", 32'(busy_w[1]), 32'd1);

    // Owner 2 releases with 5 pending: one GAP, then 5.
    req = 8'h24;
    tick();
    req = 8'h20;
    tick();
    check_eq("gap_en",   32'(en_w[1]),   32'd0);
    check_eq("gap_gnt",  32'(gnt_w[1]),  32'h00);
    check_eq("gap_busy", 32'(busy_w[1]), 32'd1);
    tick();
    check_eq("next_sel", 32'(sel_w[1]), 32'd5);
    check_eq("next_gnt", 32'(gnt_w[1]), 32'h20);

    // All requesting, MAX_HOLD=4: 4 grant cycles per owner, then one GAP.
    do_reset();
    req = 8'hFF;
    for (int c = 0; c < 45; c++) begin
      tick();
      check_eq($sformatf("rot_en_c%0d", c), 32'(en_w[0]), 32'((c % 5) != 4));
      if ((c % 5) != 4)
        check_eq($sformatf("rot_sel_c%0d", c), 32'(sel_w[0]), 32'((c / 5) % 8));
    end

    // Lone requester keeps the grant indefinitely, counter saturates.
    do_reset();
    req = 8'h08;
    for (int c = 0; c < 40; c++) begin
      tick();
      check_eq($sformatf("lone_sel_c%0d", c), 32'(sel_w[1]), 32'd3);
      check_eq($sformatf("lone_en_c%0d", c),  32'(en_w[1]),  32'd1);
    end
    check_eq("lone_cnt16", 32'(dut16.hold_cnt), 32'd16);
    check_eq("lone_cnt4",  32'(dut4.hold_cnt),  32'd4);

    // Asynchronous reset between edges drops the grant at once.
    #2 rst = 1'b1;
    #1;
    for (int m = 0; m < 2; m++) begin
      check_eq($sformatf("arst_en[%0d]", m),   32'(en_w[m]),   32'd0);
      check_eq($sformatf("arst_gnt[%0d]", m),  32'(gnt_w[m]),  32'd0);
      check_eq($sformatf("arst_busy[%0d]", m), 32'(busy_w[m]), 32'd0);
    end
    tick();
    rst = 1'b0;
    req = 8'h81;
    tick();
    check_eq("post_rst_sel", 32'(sel_w[0]), 32'd0);
    check_eq("post_rst_gnt", 32'(gnt_w[0]), 32'h01);

    // Release on the very cycle the hold limit is reached.
    do_reset();
    req = 8'h11;
    tick(); tick(); tick(); tick();
    check_eq("coin_pre_sel", 32'(sel_w[0]), 32'd0);
    check_eq("coin_pre_cnt", 32'(dut4.hold_cnt), 32'd4);
    req = 8'h10;
    tick();
    check_eq("coin_gap_en",   32'(en_w[0]),   32'd0);
    check_eq("coin_gap_busy", 32'(busy_w[0]), 32'd1);
    tick();
    check_eq("coin_next_sel", 32'(sel_w[0]), 32'd4);
    check_eq("coin_next_gnt", 32'(gnt_w[0]), 32'h10);

    // Randomized traffic with occasional mid-cycle reset pulses.
    do_reset();
    for (int c = 0; c < 800; c++) begin
      case ($urandom_range(0, 5))
        0:       req = 8'($urandom);
        1, 2:    req = req ^ (8'(1) << $urandom_range(0, 7));
        default: req = req;
      endcase
      if ($urandom_range(0, 99) == 0) begin
        #2 rst = 1'b1;
        #2 rst = 1'b0;
      end
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
